// File: rtl/dbg_error_monitor.sv
// Debug error monitor: per-source edge counters, sticky status with interrupt mask,
// first-error capture with timestamp, all behind a req/ack register port.
module dbg_error_monitor #(
  parameter logic [31:0] DBG_BASE = 32'h2000_0000,
  parameter int          NUM_ERR  = 4,
  parameter int          CNT_W    = 16,
  parameter int          TS_W     = 32,
  parameter logic [31:0] DBG_ID   = 32'hDB60_0002
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [31:0]        dbg_addr,
  input  logic [31:0]        dbg_wdata,
  output logic               dbg_ack,
  output logic [31:0]        dbg_rdata,
  output logic               dbg_err,
  input  logic [NUM_ERR-1:0] err_in,
  output logic               irq
);

  localparam logic [31:0] CNT_END = 32'h20 + 32'(4 * NUM_ERR);

  logic [NUM_ERR-1:0] prev_err;
  logic [NUM_ERR-1:0] events;
  logic               count_en;
  logic               freeze;
  logic [NUM_ERR-1:0] sticky;
  logic [NUM_ERR-1:0] irq_mask;
  logic               first_valid;
  logic [3:0]         first_idx;
  logic [TS_W-1:0]    first_ts;
  logic [TS_W-1:0]    ts;
  logic [CNT_W-1:0]   cnt [NUM_ERR];

  logic [31:0]        offset;
  logic               mapped;
  logic               bad_addr;
  logic               wr_ok;
  logic               wr_ctrl;
  logic               wr_sticky;
  logic               wr_mask;
  logic               clear_all;
  logic [3:0]         first_src;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^dbg_wdata;

  assign events    = err_in & ~prev_err;
  assign offset    = dbg_addr - DBG_BASE;
  assign bad_addr  = (dbg_addr[1:0] != 2'b00) || !mapped;
  assign wr_ok     = dbg_req && dbg_we && !bad_addr;
  assign wr_ctrl   = wr_ok && (offset == 32'h04);
  assign wr_sticky = wr_ok && (offset == 32'h08);
  assign wr_mask   = wr_ok && (offset == 32'h0C);
  assign clear_all = wr_ctrl && dbg_wdata[2];
  assign irq       = |(sticky & irq_mask);

  // Addresses below the base wrap to huge offsets and fall out as unmapped.
  always_comb begin
    mapped = 1'b0;
    case (offset)
      32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18: mapped = 1'b1;
      default: mapped = (offset >= 32'h20) && (offset < CNT_END);
    endcase
  end

  always_comb begin
    first_src = 4'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (events[i]) first_src = 4'(i);
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (offset)
      32'h00:  rd_val = DBG_ID;
      32'h04:  rd_val = {30'd0, freeze, count_en};
      32'h08:  rd_val = 32'(sticky);
      32'h0C:  rd_val = 32'(irq_mask);
      32'h10:  rd_val = {first_valid, 27'd0, first_idx};
      32'h14:  rd_val = 32'(first_ts);
      32'h18:  rd_val = 32'(ts);
      default: rd_val = 32'd0;
    endcase
    for (int i = 0; i < NUM_ERR; i++) begin
      if (offset == 32'h20 + 32'(4 * i)) rd_val = 32'(cnt[i]);
    end
  end

  // Response is registered: ack, error and read data all appear one cycle after req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= 32'd0;
    end else begin
      dbg_ack   <= dbg_req;
      dbg_err   <= dbg_req && bad_addr;
      dbg_rdata <= (dbg_req && !dbg_we && !bad_addr) ? rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_err <= '0;
      count_en <= 1'b1;
      freeze   <= 1'b0;
      irq_mask <= '0;
    end else begin
      prev_err <= err_in;
      if (wr_ctrl) begin
        count_en <= dbg_wdata[0];
        freeze   <= dbg_wdata[1];
      end
      if (wr_mask) irq_mask <= dbg_wdata[NUM_ERR-1:0];
    end
  end

  // Sticky set beats a same-cycle W1C; clear_all beats everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky      <= '0;
      ts          <= '0;
      first_valid <= 1'b0;
      first_idx   <= 4'd0;
      first_ts    <= '0;
    end else if (clear_all) begin
      sticky      <= '0;
      ts          <= '0;
      first_valid <= 1'b0;
      first_idx   <= 4'd0;
      first_ts    <= '0;
    end else begin
      sticky <= (sticky & ~(wr_sticky ? dbg_wdata[NUM_ERR-1:0] : '0)) | events;
      if (!freeze) ts <= ts + TS_W'(1);
      if (!first_valid && (|events)) begin
        first_valid <= 1'b1;
        first_idx   <= first_src;
        first_ts    <= ts;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ERR; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ERR; i++) begin
        if (clear_all) begin
          cnt[i] <= '0;
        end else if (events[i] && count_en && !freeze && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_error_monitor.sv
// Scoreboard bench for dbg_error_monitor: a cycle-level reference model predicts every
// response, a negedge monitor compares them; directed scenarios plus randomized traffic.
module tb_dbg_error_monitor;

  localparam logic [31:0] BASE    = 32'h2000_0000;
  localparam logic [31:0] ID_VAL  = 32'hDB60_0002;
  localparam int          NE      = 4;
  localparam int          CW      = 4;
  localparam int          TW      = 32;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [31:0]   dbg_addr = 32'd0;
  logic [31:0]   dbg_wdata = 32'd0;
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;
  logic          dbg_err;
  logic [NE-1:0] err_in = '0;
  logic          irq;

  dbg_error_monitor #(
    .DBG_BASE(BASE), .NUM_ERR(NE), .CNT_W(CW), .TS_W(TW), .DBG_ID(ID_VAL)
  ) dut (
    .clk(clk), .rst(rst), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .err_in(err_in), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  bit [NE-1:0] m_prev = '0;
  bit [NE-1:0] m_sticky = '0;
  bit [NE-1:0] m_mask = '0;
  bit          m_en = 1'b1;
  bit          m_frz = 1'b0;
  bit          m_fvalid = 1'b0;
  int          m_fidx = 0;
  longint      m_fts = 0;
  longint      m_ts = 0;
  int          m_cnt[NE] = '{default: 0};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_mapped(input logic [31:0] off);
    return (off inside {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18}) ||
           (off >= 32'h20 && off < 32'h20 + 32'(4 * NE));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] v;
    v = 32'd0;
    case (off)
      32'h00: v = ID_VAL;
      32'h04: v = {30'd0, m_frz, m_en};
      32'h08: v = 32'(m_sticky);
      32'h0C: v = 32'(m_mask);
      32'h10: v = (m_fvalid ? 32'h8000_0000 : 32'd0) | 32'(m_fidx);
      32'h14: v = m_fts[31:0];
      32'h18: v = m_ts[31:0];
      default: v = 32'(m_cnt[(off - 32'h20) / 4]);
    endcase
    return v;
  endfunction

  // Reference model: one step per clock, working from the register-level rules.
  always @(posedge clk or posedge rst) begin : ref_model
    logic [31:0] off;
    bit          bad;
    bit          wr;
    bit          clr;
    bit [NE-1:0] ev;
    exp_t        e;
    if (rst) begin
      m_prev = '0; m_sticky = '0; m_mask = '0; m_en = 1'b1; m_frz = 1'b0;
      m_fvalid = 1'b0; m_fidx = 0; m_fts = 0; m_ts = 0;
      for (int i = 0; i < NE; i++) m_cnt[i] = 0;
      exp_q.delete();
    end else begin
      off = dbg_addr - BASE;
      bad = (dbg_addr[1:0] != 2'b00) || !is_mapped(off);
      wr  = dbg_req && dbg_we && !bad;
      clr = 1'b0;
      ev  = err_in & ~m_prev;
      if (dbg_req) begin
        e.err   = bad;
        e.rdata = (!dbg_we && !bad) ? model_read(off) : 32'd0;
        exp_q.push_back(e);
      end
      for (int i = 0; i < NE; i++)
        if (ev[i] && m_en && !m_frz && m_cnt[i] < CNT_MAX) m_cnt[i]++;
      if (!m_fvalid && ev != 0) begin
        m_fvalid = 1'b1;
        m_fts = m_ts;
        for (int i = NE - 1; i >= 0; i--) if (ev[i]) m_fidx = i;
      end
      if (!m_frz) m_ts = (m_ts + 1) % (longint'(1) << TW);
      if (wr && off == 32'h08) m_sticky = m_sticky & ~dbg_wdata[NE-1:0];
      m_sticky = m_sticky | ev;
      if (wr && off == 32'h04) begin
        m_en  = dbg_wdata[0];
        m_frz = dbg_wdata[1];
        clr   = dbg_wdata[2];
      end
      if (wr && off == 32'h0C) m_mask = dbg_wdata[NE-1:0];
      if (clr) begin
        for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        m_sticky = '0; m_fvalid = 1'b0; m_fidx = 0; m_fts = 0; m_ts = 0;
      end
      m_prev = err_in;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("ack", {31'd0, dbg_ack}, 32'd1);
        check_output("rdata", dbg_rdata, e.rdata);
        check_output("err", {31'd0, dbg_err}, {31'd0, e.err});
      end else begin
        check_output("idle_ack", {31'd0, dbg_ack}, 32'd0);
      end
      check_output("irq", {31'd0, irq}, {31'd0, |(m_sticky & m_mask)});
    end
  end

  task automatic apply_stimulus(input bit req, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [NE-1:0] err);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    err_in    = err;
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
  endtask

  task automatic idle(input logic [NE-1:0] err, input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, err);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, 1'b1, addr, data, err_in);
  endtask

  task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp,
                           input logic [31:0] mask, input bit exp_err);
    apply_stimulus(1'b1, 1'b0, addr, 32'd0, err_in);
    @(negedge clk);
    check_output(name, dbg_rdata & mask, exp);
    check_output({name, "_err"}, {31'd0, dbg_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_ack", {31'd0, dbg_ack}, 32'd0);
    check_output("rst_rdata", dbg_rdata, 32'd0);
    check_output("rst_err", {31'd0, dbg_err}, 32'd0);
    check_output("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    rd_expect("id", BASE, ID_VAL, 32'hFFFF_FFFF, 1'b0);
    rd_expect("ctrl_rst", BASE + 32'h04, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Level held high counts once; two further pulses make three events.
    idle(4'b0100, 5);
    idle(4'b0000, 1);
    repeat (2) begin
      idle(4'b0100, 1);
      idle(4'b0000, 1);
    end
    wr(BASE + 32'h0C, 32'h4);
    rd_expect("cnt2", BASE + 32'h28, 32'd3, 32'hFFFF_FFFF, 1'b0);
    rd_expect("sticky4", BASE + 32'h08, 32'h4, 32'hFFFF_FFFF, 1'b0);
    check_output("irq_set", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h08, 32'h4);
    check_output("irq_clr", {31'd0, irq}, 32'd0);
    rd_expect("sticky_w1c", BASE + 32'h08, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // Saturation of the 4-bit counter.
    repeat (20) begin
      idle(4'b0001, 1);
      idle(4'b0000, 1);
    end
    rd_expect("cnt0_sat", BASE + 32'h20, 32'd15, 32'hFFFF_FFFF, 1'b0);
    idle(4'b0001, 1);
    idle(4'b0000, 1);
    rd_expect("cnt0_hold", BASE + 32'h20, 32'd15, 32'hFFFF_FFFF, 1'b0);

    // First-error capture at timestamp 100, simultaneous sources 1 and 3.
    wr(BASE + 32'h04, 32'h5);
    idle(4'b0000, 100);
    idle(4'b1010, 1);
    idle(4'b0000, 1);
    rd_expect("first_err", BASE + 32'h10, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    rd_expect("first_ts", BASE + 32'h14, 32'd100, 32'hFFFF_FFFF, 1'b0);
    rd_expect("cnt1_multi", BASE + 32'h24, 32'd1, 32'hFFFF_FFFF, 1'b0);
    rd_expect("cnt3_multi", BASE + 32'h2C, 32'd1, 32'hFFFF_FFFF, 1'b0);
    idle(4'b0001, 1);
    idle(4'b0000, 1);
    rd_expect("first_err_keep", BASE + 32'h10, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    rd_expect("first_ts_keep", BASE + 32'h14, 32'd100, 32'hFFFF_FFFF, 1'b0);

    // Set beats W1C; clear_all beats a same-cycle event.
    apply_stimulus(1'b1, 1'b1, BASE + 32'h08, 32'h2, 4'b0010);
    idle(4'b0000, 1);
    rd_expect("set_wins", BASE + 32'h08, 32'h2, 32'h2, 1'b0);
    apply_stimulus(1'b1, 1'b1, BASE + 32'h04, 32'h5, 4'b0001);
    idle(4'b0000, 1);
    for (int i = 0; i < NE; i++)
      rd_expect("clr_cnt", BASE + 32'h20 + 32'(4 * i), 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd_expect("clr_first", BASE + 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd_expect("clr_sticky", BASE + 32'h08, 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd_expect("ctrl_no_clr", BASE + 32'h04, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Address errors and RO writes.
    rd_expect("unmapped30", BASE + 32'h30, 32'd0, 32'hFFFF_FFFF, 1'b1);
    rd_expect("misaligned", BASE + 32'h05, 32'd0, 32'hFFFF_FFFF, 1'b1);
    rd_expect("hole1c", BASE + 32'h1C, 32'd0, 32'hFFFF_FFFF, 1'b1);
    rd_expect("below_base", BASE - 32'h4, 32'd0, 32'hFFFF_FFFF, 1'b1);
    wr(BASE, 32'h1234_5678);
    rd_expect("id_ro", BASE, ID_VAL, 32'hFFFF_FFFF, 1'b0);

    // Freeze: counter and timestamp hold, sticky still sets.
    wr(BASE + 32'h04, 32'h3);
    idle(4'b0001, 1);
    idle(4'b0000, 1);
    rd_expect("frz_cnt0", BASE + 32'h20, 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd_expect("frz_sticky", BASE + 32'h08, 32'h1, 32'h1, 1'b0);
    wr(BASE + 32'h04, 32'h1);

    // Reset while a read is in flight: no ack may appear.
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = BASE;
    @(posedge clk);
    #2;
    dbg_req = 1'b0;
    rst = 1'b1;
    #1;
    check_output("rst_mid_ack", {31'd0, dbg_ack}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_expect("ctrl_after_rst", BASE + 32'h04, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Randomized traffic checked only through the scoreboard.
    for (int k = 0; k < 2000; k++) begin
      logic [31:0]   off;
      logic [31:0]   wd;
      logic [NE-1:0] e;
      bit            req;
      bit            we;
      e = err_in;
      if ($urandom_range(0, 2) == 0) e = NE'($urandom);
      req = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) off = 32'($urandom_range(0, 63));
      else off = 32'($urandom_range(0, 14) * 4);
      wd = $urandom;
      if (off == 32'h04)
        wd = {29'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0};
      apply_stimulus(req, we, BASE + off, wd, e);
    end
    idle('0, 3);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
